// File: rtl/regfile_multiport.sv
// Register file: NRD combinational reads, two sync writes, sweep clear.
// Define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module regfile_multiport #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NRD      = 2,
   parameter int ZERO_REG = 1
) (
   input  logic                  iClk,
   input  logic                  iReset_n,
   input  logic                  iClear,
   input  logic [NRD*ADDR_W-1:0] iRaddr,
   output logic [NRD*DATA_W-1:0] oRdata,
   input  logic                  iWeA,
   input  logic [ADDR_W-1:0]     iWaddrA,
   input  logic [DATA_W-1:0]     iWdataA,
   input  logic                  iWeB,
   input  logic [ADDR_W-1:0]     iWaddrB,
   input  logic [DATA_W-1:0]     iWdataB,
   output logic                  oBusy
);

   localparam int NREG = 2 ** ADDR_W;

   typedef enum logic {
      CLEAR,
      READY
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [ADDR_W-1:0] idx;
   logic [ADDR_W-1:0] idx_nxt;
   logic [DATA_W-1:0] mem [NREG];
   logic              busy;
   logic              wr_a;
   logic              wr_b;

   assign busy  = (state == CLEAR);
   assign oBusy = busy;

   // Writes to the hardwired zero entry never reach the array.
   assign wr_a = !busy && iWeA
               && !(ZERO_REG != 0 && iWaddrA == '0);
   assign wr_b = !busy && iWeB
               && !(ZERO_REG != 0 && iWaddrB == '0);

   always_ff @(posedge iClk or negedge iReset_n) begin
      if (!iReset_n) begin
         state <= CLEAR;
         idx   <= '0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      unique case (state)
         CLEAR: begin
            idx_nxt = idx + 1'b1;
            if (&idx) state_nxt = READY;
         end
         READY: begin
            if (iClear) begin
               state_nxt = CLEAR;
               idx_nxt   = '0;
            end
         end
         default: begin
            state_nxt = CLEAR;
            idx_nxt   = '0;
         end
      endcase
   end

   // B is written last so it wins an address collision with A.
   always_ff @(posedge iClk) begin
      if (busy) begin
         mem[idx] <= '0;
      end else begin
         if (wr_a) mem[iWaddrA] <= iWdataA;
         if (wr_b) mem[iWaddrB] <= iWdataB;
      end
   end

   for (genvar k = 0; k < NRD; k++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      logic [DATA_W-1:0] rd;

      assign ra = iRaddr[k*ADDR_W +: ADDR_W];

      always_comb begin
         rd = mem[ra];
`ifdef REGFILE_BYPASS_EN
         if (wr_b && iWaddrB == ra)
            rd = iWdataB;
         else if (wr_a && iWaddrA == ra)
            rd = iWdataA;
`endif
         if (busy || (ZERO_REG != 0 && ra == '0))
            rd = '0;
      end

      assign oRdata[k*DATA_W +: DATA_W] = rd;
   end

endmodule

// File: tb/tb_regfile_multiport.sv
// Scoreboard bench for regfile_multiport: clear sweep, writes, collisions,
// bypass behaviour and reset during a sweep.
module tb_regfile_multiport;

   localparam int DW   = 32;
   localparam int AW   = 5;
   localparam int NRD  = 2;
   localparam int NREG = 32;

   typedef struct {
      string          name;
      int             port;
      logic [DW-1:0]  exp;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              clr = 1'b0;
   logic [NRD*AW-1:0] raddr = '0;
   logic [NRD*DW-1:0] rdata;
   logic              we_a = 1'b0;
   logic [AW-1:0]     wa_a = '0;
   logic [DW-1:0]     wd_a = '0;
   logic              we_b = 1'b0;
   logic [AW-1:0]     wa_b = '0;
   logic [DW-1:0]     wd_b = '0;
   logic              busy;

   int                checks = 0;
   int                failures = 0;
   logic [DW-1:0]     mdl [NREG];
   exp_t              sb [$];
   exp_t              e;
   logic [DW-1:0]     got;

   regfile_multiport dut (
      .iClk     (clk),
      .iReset_n (rst_n),
      .iClear   (clr),
      .iRaddr   (raddr),
      .oRdata   (rdata),
      .iWeA     (we_a),
      .iWaddrA  (wa_a),
      .iWdataA  (wd_a),
      .iWeB     (we_b),
      .iWaddrB  (wa_b),
      .iWdataB  (wd_b),
      .oBusy    (busy)
   );

   always #5 clk = ~clk;

   task automatic rd_set(input string n, input int p,
                         input logic [AW-1:0] a,
                         input logic [DW-1:0] ex);
      raddr[p*AW +: AW] = a;
      sb.push_back('{n, p, ex});
   endtask

   task automatic wr(input logic ea, input logic [AW-1:0] aa,
                     input logic [DW-1:0] da, input logic eb,
                     input logic [AW-1:0] ab, input logic [DW-1:0] db,
                     input bit upd);
      we_a = ea; wa_a = aa; wd_a = da;
      we_b = eb; wa_b = ab; wd_b = db;
      @(posedge clk); #1;
      we_a = 1'b0; we_b = 1'b0;
      if (upd) begin
         if (ea && aa != 0) mdl[aa] = da;
         if (eb && ab != 0) mdl[ab] = db;
      end
   endtask

   task automatic test_reset;
      int n;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rd_set("rst_rd0", 0, 5'd3, 32'h0);
      rd_set("rst_rd1", 1, 5'd17, 32'h0);
      @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL rst_busy got=%b exp=1", busy);
      end
      while (sb.size() > 0) begin
         e = sb.pop_front(); got = rdata[e.port*DW +: DW]; checks++;
         if (got !== e.exp) begin
            failures++;
            $display("FAIL %s port%0d got=%h exp=%h", e.name, e.port, got, e.exp);
         end
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      n = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (busy !== 1'b1) break;
         n++;
      end
      checks++;
      if (n != NREG) begin
         failures++;
         $display("FAIL rst_sweep_len got=%0d exp=%0d", n, NREG);
      end
      for (int i = 0; i < NREG; i++) mdl[i] = '0;
      for (int i = 0; i < NREG; i++) begin
         rd_set("rst_all", 0, AW'(i), mdl[i]);
         rd_set("rst_all", 1, AW'(NREG-1-i), mdl[NREG-1-i]);
         @(negedge clk);
         while (sb.size() > 0) begin
            e = sb.pop_front(); got = rdata[e.port*DW +: DW]; checks++;
            if (got !== e.exp) begin
               failures++;
               $display("FAIL %s port%0d got=%h exp=%h", e.name, e.port, got, e.exp);
            end
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_write_read;
      wr(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 1'b1);
      rd_set("wr_r5_p0", 0, 5'd5, mdl[5]);
      rd_set("wr_r5_p1", 1, 5'd5, 32'hDEADBEEF);
      @(negedge clk);
      while (sb.size() > 0) begin
         e = sb.pop_front(); got = rdata[e.port*DW +: DW]; checks++;
         if (got !== e.exp) begin
            failures++;
            $display("FAIL %s port%0d got=%h exp=%h", e.name, e.port, got, e.exp);
         end
      end
      @(posedge clk); #1;
      wr(1'b1, 5'd0, 32'h1234, 1'b1, 5'd0, 32'h5678, 1'b1);
      rd_set("zero_p0", 0, 5'd0, 32'h0);
      rd_set("zero_p1", 1, 5'd0, mdl[0]);
      @(negedge clk);
      while (sb.size() > 0) begin
         e = sb.pop_front(); got = rdata[e.port*DW +: DW]; checks++;
         if (got !== e.exp) begin
            failures++;
            $display("FAIL %s port%0d got=%h exp=%h", e.name, e.port, got, e.exp);
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_collision;
      wr(1'b1, 5'd7, 32'h11111111, 1'b1, 5'd7, 32'h22222222, 1'b1);
      rd_set("coll_r7", 0, 5'd7, 32'h22222222);
      rd_set("coll_r7_mdl", 1, 5'd7, mdl[7]);
      @(negedge clk);
      while (sb.size() > 0) begin
         e = sb.pop_front(); got = rdata[e.port*DW +: DW]; checks++;
         if (got !== e.exp) begin
            failures++;
            $display("FAIL %s port%0d got=%h exp=%h", e.name, e.port, got, e.exp);
         end
      end
      @(posedge clk); #1;
      wr(1'b1, 5'd3, 32'h33333333, 1'b1, 5'd4, 32'h44444444, 1'b1);
      rd_set("dual_r3", 0, 5'd3, 32'h33333333);
      rd_set("dual_r4", 1, 5'd4, 32'h44444444);
      @(negedge clk);
      while (sb.size() > 0) begin
         e = sb.pop_front(); got = rdata[e.port*DW +: DW]; checks++;
         if (got !== e.exp) begin
            failures++;
            $display("FAIL %s port%0d got=%h exp=%h", e.name, e.port, got, e.exp);
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_bypass;
      we_b = 1'b1; wa_b = 5'd9; wd_b = 32'hCAFEF00D;
`ifdef REGFILE_BYPASS_EN
      rd_set("byp_same", 0, 5'd9, 32'hCAFEF00D);
`else
      rd_set("byp_same", 0, 5'd9, 32'h0);
`endif
      rd_set("byp_r5", 1, 5'd5, mdl[5]);
      @(negedge clk);
      while (sb.size() > 0) begin
         e = sb.pop_front(); got = rdata[e.port*DW +: DW]; checks++;
         if (got !== e.exp) begin
            failures++;
            $display("FAIL %s port%0d got=%h exp=%h", e.name, e.port, got, e.exp);
         end
      end
      @(posedge clk); #1;
      we_b = 1'b0;
      mdl[9] = 32'hCAFEF00D;
      rd_set("byp_next", 0, 5'd9, mdl[9]);
      @(negedge clk);
      while (sb.size() > 0) begin
         e = sb.pop_front(); got = rdata[e.port*DW +: DW]; checks++;
         if (got !== e.exp) begin
            failures++;
            $display("FAIL %s port%0d got=%h exp=%h", e.name, e.port, got, e.exp);
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back;
      for (int i = 10; i < 14; i++)
         wr(1'b1, AW'(i), 32'h0B0B0000 + i, 1'b1, AW'(i + 10),
            32'h0C0C0000 + i, 1'b1);
      for (int i = 10; i < 14; i++) begin
         rd_set("b2b_a", 0, AW'(i), mdl[i]);
         rd_set("b2b_b", 1, AW'(i + 10), mdl[i + 10]);
         @(negedge clk);
         while (sb.size() > 0) begin
            e = sb.pop_front(); got = rdata[e.port*DW +: DW]; checks++;
            if (got !== e.exp) begin
               failures++;
               $display("FAIL %s port%0d got=%h exp=%h", e.name, e.port, got, e.exp);
            end
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_clear;
      int n;
      for (int i = 1; i < NREG; i += 2)
         wr(1'b1, AW'(i), 32'hA5000000 | (i * 32'h111),
            (i + 1) < NREG, AW'(i + 1), 32'h5A000000 | ((i + 1) * 32'h111), 1'b1);
      for (int i = 0; i < NREG; i += 4) begin
         rd_set("fill", 0, AW'(i + 1), mdl[i + 1]);
         rd_set("fill", 1, AW'(i + 2), mdl[i + 2]);
         @(negedge clk);
         while (sb.size() > 0) begin
            e = sb.pop_front(); got = rdata[e.port*DW +: DW]; checks++;
            if (got !== e.exp) begin
               failures++;
               $display("FAIL %s port%0d got=%h exp=%h", e.name, e.port, got, e.exp);
            end
         end
         @(posedge clk); #1;
      end
      clr = 1'b1;
      @(posedge clk); #1;
      clr = 1'b0;
      for (int i = 0; i < NREG; i++) mdl[i] = '0;
      raddr[0 +: AW] = 5'd31;
      n = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (busy !== 1'b1) break;
         n++;
         if (i == 5) begin
            checks++;
            if (rdata[0 +: DW] !== 32'h0) begin
               failures++;
               $display("FAIL clr_busy_rd got=%h exp=0", rdata[0 +: DW]);
            end
         end
         we_a = 1'b1; wa_a = AW'($urandom_range(1, NREG - 1)); wd_a = $urandom | 1;
         we_b = 1'b1; wa_b = AW'($urandom_range(1, NREG - 1)); wd_b = $urandom | 1;
      end
      we_a = 1'b0; we_b = 1'b0;
      checks++;
      if (n != NREG) begin
         failures++;
         $display("FAIL clr_sweep_len got=%0d exp=%0d", n, NREG);
      end
      @(posedge clk); #1;
      for (int i = 0; i < NREG; i++) begin
         rd_set("clr_all", 0, AW'(i), mdl[i]);
         rd_set("clr_all", 1, AW'(NREG-1-i), mdl[NREG-1-i]);
         @(negedge clk);
         while (sb.size() > 0) begin
            e = sb.pop_front(); got = rdata[e.port*DW +: DW]; checks++;
            if (got !== e.exp) begin
               failures++;
               $display("FAIL %s port%0d got=%h exp=%h", e.name, e.port, got, e.exp);
            end
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset_mid_sweep;
      int n;
      wr(1'b1, 5'd20, 32'h20202020, 1'b0, 5'd0, 32'h0, 1'b1);
      clr = 1'b1;
      @(posedge clk); #1;
      clr = 1'b0;
      for (int i = 0; i < NREG; i++) mdl[i] = '0;
      repeat (10) @(posedge clk);
      #1 rst_n = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL mid_rst_busy got=%b exp=1", busy);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      n = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (busy !== 1'b1) break;
         n++;
      end
      checks++;
      if (n != NREG) begin
         failures++;
         $display("FAIL mid_sweep_len got=%0d exp=%0d", n, NREG);
      end
      @(posedge clk); #1;
      wr(1'b0, 5'd0, 32'h0, 1'b1, 5'd31, 32'h31313131, 1'b1);
      rd_set("post_r31", 0, 5'd31, mdl[31]);
      rd_set("post_r20", 1, 5'd20, mdl[20]);
      @(negedge clk);
      while (sb.size() > 0) begin
         e = sb.pop_front(); got = rdata[e.port*DW +: DW]; checks++;
         if (got !== e.exp) begin
            failures++;
            $display("FAIL %s port%0d got=%h exp=%h", e.name, e.port, got, e.exp);
         end
      end
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_collision();
      test_bypass();
      test_back_to_back();
      test_clear();
      test_reset_mid_sweep();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
